uart_rx_fifo_param: RTL and testbench
=====================================

Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver with 16x oversampling, majority-vote bit decisions, optional parity, 1 or 2 stop bits and an integrated show-ahead receive FIFO. It supersedes the fixed 8N1 receive path in the transceiver top. It feeds keypad/segment logic through the rdreq/rdata/rdempty interface, and adds fill level and error reporting.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, receive FIFO entries, power of 2, minimum 2
FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
uart_rxd  in  1  asynchronous serial input, idle high
rdreq  in  1  pop request
rdata  out  DATA_BITS  head-of-FIFO word, valid while rdempty=0
rdempty  out  1  FIFO empty
rdfull  out  1  FIFO full
rdusedw  out  FIFO_AW+1  current entry count
frame_err  out  1  one-cycle pulse on a bad stop bit
parity_err  out  1  one-cycle pulse on a parity mismatch
overrun  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full
busy  out  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset values: rdata=0, rdempty=1, rdfull=0, rdusedw=0, all error pulses 0, busy=0.
- Reset effects: FIFO pointers cleared, FSM to IDLE, synchroniser flops set to 1. Reset mid-frame aborts the frame with no flags.
- Input: uart_rxd passes through a 2-flop synchroniser. A falling-edge detect is taken on the synchronised signal.
- Oversample tick: DIV = (CLK_FREQ + 8*BAUD)/(16*BAUD), which gives 326 at the defaults. The divider counts 0..DIV-1 and ticks at DIV-1. It is forced to 0 on a start-edge detect in IDLE.
- Within each bit, a 4-bit sample counter runs 0..15 on ticks. Samples are taken at counts 7, 8 and 9; the bit value is the majority (2 of 3). The decision is available at count 9. The bit ends at count 15.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> START on the falling edge.
- START, at count 9: majority 1 -> false start, back to IDLE, no flags. Majority 0 -> continue; the state moves to DATA at count 15.
- DATA: shift LSB-first, DATA_BITS bits. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: compare the sampled bit with the computed parity of the data. Odd: data XOR parity bit = 1. Even: data XOR parity bit = 0. Latch the mismatch.
- STOP: each stop bit must decide 1. The final stop bit's decision (count 9) is the commit point. The FSM returns to IDLE immediately at commit, without waiting for count 15, so that back-to-back frames resync.
- Commit priority, applied exactly once per frame:
  - Any stop bit 0 -> frame_err pulse, word discarded, go to BREAK.
  - Else parity mismatch -> parity_err pulse, word discarded.
  - Else FIFO full with no same-cycle pop -> overrun pulse, word discarded, FIFO unchanged.
  - Else write.
- BREAK: stay until the synchronised line reads 1, then IDLE. A long break produces exactly one frame_err.
- Latency: write at the commit cycle. rdempty deasserts and rdata is valid on the next clk edge.
- FIFO is show-ahead. rdreq with rdempty=0 pops, and the next word appears the following cycle. rdreq while empty is ignored, with no underflow.
- Simultaneous write and pop: both occur and rdusedw is unchanged. When full, a pop in the commit cycle allows the write with no overrun.
- rdfull = (rdusedw == FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- With DATA_BITS < 8 the data is right-aligned. The width is exactly DATA_BITS, with no padding.

Test Plan:
1. Defaults, rdreq=0; send 8N1 0x55 with a 104166 ns bit time -> rdata=0x55, rdempty 1->0, rdusedw=1, no error pulses, busy low after the stop bit centre.
2. Idle line, 2 us low glitch -> no write, no flags, busy returns to 0 within 1 bit time.
3. PARITY=2. Send 0x55 with parity bit 1 -> one parity_err pulse, FIFO empty. Then send 0x55 with parity bit 0 -> rdata=0x55.
4. Hold the stop bit low, with the line low for 20 bit times -> exactly one frame_err, no write. Then send 0xA3 -> rdata=0xA3 with no flags.
5. FIFO_DEPTH=4, rdreq=0; send 0x01..0x05 back-to-back.
   - rdfull rises after 0x04; overrun pulses on 0x05.
   - Drain with rdreq=1 -> 0x01, 0x02, 0x03, 0x04 on consecutive cycles; rdusedw 4->0; rdempty=1.
6. Assert rst_n=0 for 2 cycles during data bit 3 of a frame -> all outputs at reset values; the next frame 0x3C is received correctly.
7. DATA_BITS=7, STOP_BITS=2, PARITY=1; send 0x5A with correct odd parity -> rdata=7'h5A, committed at the second stop bit centre.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
// UART receiver (16x oversampling, 2-of-3 majority, optional parity, 1/2 stop bits) with show-ahead receive FIFO.
// Latency: word is written at the final stop bit decision; rdata/rdempty reflect it on the next clk edge.
// Backpressure: none on the line; a good frame arriving while the FIFO is full (and not popped that cycle) is dropped with an overrun pulse.
module uart_rx_fifo_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  input  logic                 rdreq,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdempty,
  output logic                 rdfull,
  output logic [FIFO_AW:0]     rdusedw,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // Rounded oversample divider; 326 at 50 MHz / 9600 baud.
  localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]    DIV_M1    = DW'(DIV - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t state, state_n;

  logic                 sync1, sync2, rxd_d;
  logic                 start_edge;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [3:0]           s_cnt;
  logic                 smp7, smp8;
  logic                 maj, dec, bit_end;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 stop_bad, par_bad;
  logic                 commit, ferr_c, perr_c, ovr_c, good, wr_en, pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;

  // Two-flop synchroniser plus one delay flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      sync2 <= sync1;
      rxd_d <= sync2;
    end
  end

  assign start_edge = (state == S_IDLE) && rxd_d && !sync2;
  assign tick       = (div_cnt == DIV_M1);
  assign dec        = tick && (s_cnt == 4'd9);
  assign bit_end    = tick && (s_cnt == 4'd15);
  assign maj        = (smp7 & smp8) | (smp7 & sync2) | (smp8 & sync2);

  // Oversample divider; realigned to the start edge so bit centres track the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (start_edge || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Per-bit sample counter and the two early samples feeding the majority vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_cnt <= '0;
      smp7  <= 1'b1;
      smp8  <= 1'b1;
    end else begin
      if (state == S_IDLE || state == S_BREAK || commit) begin
        s_cnt <= '0;
      end else if (tick) begin
        s_cnt <= s_cnt + 1'b1;
      end
      if (tick && s_cnt == 4'd7) smp7 <= sync2;
      if (tick && s_cnt == 4'd8) smp8 <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and the once-per-frame commit decision.
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      S_IDLE:   if (start_edge) state_n = S_START;
      S_START: begin
        if (dec && maj)   state_n = S_IDLE;
        else if (bit_end) state_n = S_DATA;
      end
      S_DATA:   if (bit_end && bit_idx == LAST_BIT)
                  state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_n = S_STOP;
      S_STOP: begin
        if (dec && stop_idx == LAST_STOP) begin
          commit  = 1'b1;
          state_n = (stop_bad || !maj) ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK:  if (sync2) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Commit priority: framing, then parity, then overrun, else write.
  always_comb begin
    pop    = rdreq && !rdempty;
    ferr_c = commit && (stop_bad || !maj);
    perr_c = commit && !ferr_c && par_bad;
    good   = commit && !ferr_c && !perr_c;
    wr_en  = good && (!rdfull || pop);
    ovr_c  = good && rdfull && !pop;
  end

  // Frame datapath: LSB-first shifter, bit/stop indices and latched error conditions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      par_bad  <= 1'b0;
    end else begin
      if (start_edge) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        stop_bad <= 1'b0;
        par_bad  <= 1'b0;
      end
      if (state == S_DATA && dec)     shreg    <= {maj, shreg[DATA_BITS-1:1]};
      if (state == S_DATA && bit_end) bit_idx  <= bit_idx + 1'b1;
      if (state == S_PARITY && dec)   par_bad  <= (^shreg) ^ maj ^ (PARITY == 1);
      if (state == S_STOP && dec && !maj) stop_bad <= 1'b1;
      if (state == S_STOP && bit_end) stop_idx <= stop_idx + 1'b1;
    end
  end

  // Registered one-cycle status pulses, aligned with the FIFO update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= ferr_c;
      parity_err <= perr_c;
      overrun    <= ovr_c;
    end
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  assign rdempty = (count == '0);
  assign rdfull  = (count == DEPTH_CNT);
  assign rdusedw = count;
  assign rdata   = rdempty ? '0 : mem[rd_ptr];
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: four configurations driven with hand-built serial frames.
// Bit time is 64 clocks (DIV=4) so every frame is short; all waits are fixed cycle counts.
// Expected words and flags come from the vector table and hand-written sequences below.
module tb_uart_rx_fifo_param;

  localparam int CLK_HZ = 6_400_000;
  localparam int BAUD_R = 100_000;
  localparam int BIT    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rstn, rxd, rdreq;
  logic [3:0] empty, full, ferr, perr, ovr, busy;
  logic [7:0] rdata0, rdata1, rdata2;
  logic [6:0] rdata3;
  logic [4:0] used0, used2, used3;
  logic [2:0] used1;

  int ferr_cnt [4] = '{default: 0};
  int perr_cnt [4] = '{default: 0};
  int ovr_cnt  [4] = '{default: 0};
  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(16), .FIFO_AW(4)) u0 (
    .clk(clk), .rst_n(rstn[0]), .uart_rxd(rxd[0]), .rdreq(rdreq[0]), .rdata(rdata0),
    .rdempty(empty[0]), .rdfull(full[0]), .rdusedw(used0), .frame_err(ferr[0]),
    .parity_err(perr[0]), .overrun(ovr[0]), .busy(busy[0]));

  uart_rx_fifo_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4), .FIFO_AW(2)) u1 (
    .clk(clk), .rst_n(rstn[1]), .uart_rxd(rxd[1]), .rdreq(rdreq[1]), .rdata(rdata1),
    .rdempty(empty[1]), .rdfull(full[1]), .rdusedw(used1), .frame_err(ferr[1]),
    .parity_err(perr[1]), .overrun(ovr[1]), .busy(busy[1]));

  uart_rx_fifo_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(8), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(16), .FIFO_AW(4)) u2 (
    .clk(clk), .rst_n(rstn[2]), .uart_rxd(rxd[2]), .rdreq(rdreq[2]), .rdata(rdata2),
    .rdempty(empty[2]), .rdfull(full[2]), .rdusedw(used2), .frame_err(ferr[2]),
    .parity_err(perr[2]), .overrun(ovr[2]), .busy(busy[2]));

  uart_rx_fifo_param #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_R), .DATA_BITS(7), .PARITY(1),
                       .STOP_BITS(2), .FIFO_DEPTH(16), .FIFO_AW(4)) u3 (
    .clk(clk), .rst_n(rstn[3]), .uart_rxd(rxd[3]), .rdreq(rdreq[3]), .rdata(rdata3),
    .rdempty(empty[3]), .rdfull(full[3]), .rdusedw(used3), .frame_err(ferr[3]),
    .parity_err(perr[3]), .overrun(ovr[3]), .busy(busy[3]));

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ferr[i] === 1'b1) ferr_cnt[i]++;
      if (perr[i] === 1'b1) perr_cnt[i]++;
      if (ovr[i]  === 1'b1) ovr_cnt[i]++;
    end
  end

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pbit;
    logic       stop_ok;
    logic       exp_wr;
    logic       exp_ferr;
    logic       exp_perr;
    logic [8:0] exp_dat;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] get_rdata(input int k);
    case (k)
      0:       return {1'b0, rdata0};
      1:       return {1'b0, rdata1};
      2:       return {1'b0, rdata2};
      default: return {2'b0, rdata3};
    endcase
  endfunction

  function automatic logic [4:0] get_used(input int k);
    case (k)
      0:       return used0;
      1:       return {2'b0, used1};
      2:       return used2;
      default: return used3;
    endcase
  endfunction

  // Drives one frame (start, data LSB-first, optional parity, stop bits) on line k.
  task automatic send_frame(input int k, input logic [8:0] d, input logic pbit, input logic stop_ok);
    logic [15:0] fr;
    int n;
    int nb;
    int ns;
    nb = (k == 3) ? 7 : 8;
    ns = (k == 3) ? 2 : 1;
    fr = '1;
    n  = 0;
    fr[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin fr[n] = d[i]; n++; end
    if (k >= 2) begin fr[n] = pbit; n++; end
    for (int i = 0; i < ns; i++) begin fr[n] = stop_ok; n++; end
    for (int i = 0; i < n; i++) begin
      rxd[k] = fr[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[k] = 1'b1;
  endtask

  task automatic pop_one(input int k);
    rdreq[k] = 1'b1;
    @(negedge clk);
    rdreq[k] = 1'b0;
  endtask

  initial begin
    int f0, p0, o0;
    logic [7:0] b3c;

    //            k  data    par   stop  wr    ferr  perr  expect
    vt[0]  = '{0, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h055};
    vt[1]  = '{0, 9'h0A3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0A3};
    vt[2]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000};
    vt[3]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0FF};
    vt[4]  = '{2, 9'h055, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000};
    vt[5]  = '{2, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h055};
    vt[6]  = '{2, 9'h080, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h080};
    vt[7]  = '{2, 9'h081, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000};
    vt[8]  = '{3, 9'h07F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h07F};
    vt[9]  = '{3, 9'h001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000};
    vt[10] = '{0, 9'h012, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000};
    vt[11] = '{3, 9'h05A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000};

    rstn  = '0;
    rxd   = '1;
    rdreq = '0;
    repeat (3) @(negedge clk);
    rstn = '1;
    @(negedge clk);

    // Reset state of every instance.
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst%0d empty", k), 32'(empty[k]), 32'd1);
      check($sformatf("rst%0d full", k), 32'(full[k]), 32'd0);
      check($sformatf("rst%0d used", k), 32'(get_used(k)), 32'd0);
      check($sformatf("rst%0d rdata", k), 32'(get_rdata(k)), 32'd0);
      check($sformatf("rst%0d busy", k), 32'(busy[k]), 32'd0);
      check($sformatf("rst%0d pulses", k), 32'(ferr[k] | perr[k] | ovr[k]), 32'd0);
    end

    // Table-driven frames.
    for (int i = 0; i < 12; i++) begin
      f0 = ferr_cnt[vt[i].k];
      p0 = perr_cnt[vt[i].k];
      send_frame(vt[i].k, vt[i].d, vt[i].pbit, vt[i].stop_ok);
      repeat (BIT) @(negedge clk);
      check($sformatf("v%0d ferr", i), 32'(ferr_cnt[vt[i].k] - f0), 32'(vt[i].exp_ferr));
      check($sformatf("v%0d perr", i), 32'(perr_cnt[vt[i].k] - p0), 32'(vt[i].exp_perr));
      check($sformatf("v%0d empty", i), 32'(empty[vt[i].k]), 32'(!vt[i].exp_wr));
      check($sformatf("v%0d used", i), 32'(get_used(vt[i].k)), 32'(vt[i].exp_wr));
      check($sformatf("v%0d busy", i), 32'(busy[vt[i].k]), 32'd0);
      if (vt[i].exp_wr) begin
        check($sformatf("v%0d rdata", i), 32'(get_rdata(vt[i].k)), 32'(vt[i].exp_dat));
        pop_one(vt[i].k);
        check($sformatf("v%0d empty after pop", i), 32'(empty[vt[i].k]), 32'd1);
      end
    end

    // Short low glitch on an idle line: false start, no write, no flags.
    f0 = ferr_cnt[0];
    p0 = perr_cnt[0];
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch busy rises", 32'(busy[0]), 32'd1);
    repeat (BIT) @(negedge clk);
    check("glitch busy falls", 32'(busy[0]), 32'd0);
    check("glitch empty", 32'(empty[0]), 32'd1);
    check("glitch flags", 32'((ferr_cnt[0] - f0) + (perr_cnt[0] - p0)), 32'd0);

    // Line held low for 20 bit times: exactly one frame error, then recovery.
    f0 = ferr_cnt[0];
    p0 = perr_cnt[0];
    rxd[0] = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    check("break ferr once", 32'(ferr_cnt[0] - f0), 32'd1);
    check("break busy", 32'(busy[0]), 32'd1);
    check("break empty", 32'(empty[0]), 32'd1);
    rxd[0] = 1'b1;
    repeat (BIT) @(negedge clk);
    check("break released", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h0A3, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check("after break rdata", 32'(rdata0), 32'h0A3);
    check("after break ferr", 32'(ferr_cnt[0] - f0), 32'd1);
    check("after break perr", 32'(perr_cnt[0] - p0), 32'd0);
    pop_one(0);

    // Fill the 4-deep FIFO back-to-back, overrun on the fifth, then drain.
    o0 = ovr_cnt[1];
    for (int i = 1; i <= 5; i++) begin
      send_frame(1, 9'(i), 1'b0, 1'b1);
      if (i == 3) check("fill full after 3", 32'(full[1]), 32'd0);
      if (i == 4) begin
        check("fill full after 4", 32'(full[1]), 32'd1);
        check("fill used after 4", 32'(used1), 32'd4);
        check("fill no ovr yet", 32'(ovr_cnt[1] - o0), 32'd0);
      end
    end
    repeat (BIT) @(negedge clk);
    check("overrun once", 32'(ovr_cnt[1] - o0), 32'd1);
    check("overrun used", 32'(used1), 32'd4);
    rdreq[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d rdata", i), 32'(rdata1), 32'(i + 1));
      check($sformatf("drain%0d used", i), 32'(used1), 32'(4 - i));
      @(negedge clk);
    end
    check("drained empty", 32'(empty[1]), 32'd1);
    check("drained full", 32'(full[1]), 32'd0);
    @(negedge clk);
    check("pop on empty used", 32'(used1), 32'd0);
    check("pop on empty rdata", 32'(rdata1), 32'd0);
    rdreq[1] = 1'b0;

    // Reset during data bit 3 with one word queued.
    send_frame(0, 9'h011, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check("pre-reset used", 32'(used0), 32'd1);
    f0 = ferr_cnt[0];
    p0 = perr_cnt[0];
    b3c = 8'h3C;
    rxd[0] = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd[0] = b3c[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[0] = b3c[3];
    repeat (BIT / 2) @(negedge clk);
    check("midframe busy", 32'(busy[0]), 32'd1);
    rstn[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset empty", 32'(empty[0]), 32'd1);
    check("midreset used", 32'(used0), 32'd0);
    check("midreset rdata", 32'(rdata0), 32'd0);
    check("midreset busy", 32'(busy[0]), 32'd0);
    check("midreset full", 32'(full[0]), 32'd0);
    rstn[0] = 1'b1;
    rxd[0]  = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("post-reset idle empty", 32'(empty[0]), 32'd1);
    send_frame(0, 9'h03C, 1'b0, 1'b1);
    repeat (BIT) @(negedge clk);
    check("post-reset rdata", 32'(rdata0), 32'h03C);
    check("post-reset flags", 32'((ferr_cnt[0] - f0) + (perr_cnt[0] - p0)), 32'd0);
    pop_one(0);

    // 7O2: commit lands at the second stop bit centre.
    f0 = ferr_cnt[3];
    p0 = perr_cnt[3];
    b3c = 8'h5A;
    rxd[3] = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rxd[3] = b3c[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[3] = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    repeat (30) @(negedge clk);
    check("7o2 not yet written", 32'(empty[3]), 32'd1);
    check("7o2 busy in stop2", 32'(busy[3]), 32'd1);
    repeat (BIT - 30) @(negedge clk);
    check("7o2 written", 32'(empty[3]), 32'd0);
    check("7o2 rdata", 32'(rdata3), 32'h5A);
    check("7o2 busy", 32'(busy[3]), 32'd0);
    check("7o2 flags", 32'((ferr_cnt[3] - f0) + (perr_cnt[3] - p0)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
